// File: rtl/device_mux_n.sv
// rtl/device_mux_n.sv - N-slave 68k-style device multiplexer with window decode, timeout and bus error
//
// Purpose:
//   Routes a 68k-style master bus cycle to one of NUM_SLAVES peripherals.
//   The master address is decoded against per-slave base/mask windows and
//   the selected slave is latched for the whole cycle. Read data and ack
//   are registered and held until the master releases its data strobes.
//   An unmapped address, or a slave that fails to ack within TIMEOUT
//   ACTIVE cycles, raises a bus error; bus errors are counted (saturating).
//
// Ports:
//   clk, reset      - clock, asynchronous active-high reset
//   master_write    - write data from CPU (passed straight to slave_write)
//   master_read     - latched read data, non-zero only while in DONE
//   master_addr     - CPU address (low SLAVE_ADDR_W bits go to slave_addr)
//   master_ds       - upper/lower data strobes, cycle active when != 00
//   master_ack      - registered transfer acknowledge
//   master_berr     - registered bus error
//   berr_count      - saturating count of transitions into ERROR
//   slave_read      - per-slave read data, slave i at [i*DATA_W +: DATA_W]
//   slave_write     - shared write data
//   slave_addr      - shared address
//   slave_ds        - per-slave strobes, slave i at [2i +: 2]
//   slave_ack       - per-slave acknowledge

module device_mux_n #(
    parameter int NUM_SLAVES   = 3,
    parameter int DATA_W       = 16,
    parameter int ADDR_W       = 32,
    parameter int SLAVE_ADDR_W = 24,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_BASE =
        {32'h0020_0000, 32'h0010_0000, 32'h0000_0000},
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_MASK =
        {32'hFFFF_0000, 32'hFFFF_FF00, 32'hFFF0_0000},
    parameter int TIMEOUT      = 255
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [DATA_W-1:0]          master_write,
    output logic [DATA_W-1:0]          master_read,
    input  logic [ADDR_W-1:0]          master_addr,
    input  logic [1:0]                 master_ds,
    output logic                       master_ack,
    output logic                       master_berr,
    output logic [7:0]                 berr_count,
    input  logic [NUM_SLAVES*DATA_W-1:0] slave_read,
    output logic [DATA_W-1:0]          slave_write,
    output logic [SLAVE_ADDR_W-1:0]    slave_addr,
    output logic [NUM_SLAVES*2-1:0]    slave_ds,
    input  logic [NUM_SLAVES-1:0]      slave_ack
);

    localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int CNT_W = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2,
        ERROR  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                ack_q, ack_d;
    logic                berr_q, berr_d;
    logic [7:0]          count_q, count_d;

    logic                hit;
    logic [SEL_W-1:0]    hit_idx;
    logic                sel_ack;
    logic [DATA_W-1:0]   sel_rdata;
    logic                ds_active;
    logic                enter_err;

    assign ds_active = (master_ds != 2'b00);

    assign slave_write = master_write;
    assign slave_addr  = master_addr[SLAVE_ADDR_W-1:0];

    // Scan from the highest index down so the lowest matching window wins.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((master_addr & SLAVE_MASK[i*ADDR_W +: ADDR_W]) ==
                SLAVE_BASE[i*ADDR_W +: ADDR_W]) begin
                hit     = 1'b1;
                hit_idx = SEL_W'(i);
            end
        end
    end

    // Mux the latched slave's ack/read data.
    always_comb begin
        sel_ack   = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (sel_q == SEL_W'(i)) begin
                sel_ack   = slave_ack[i];
                sel_rdata = slave_read[i*DATA_W +: DATA_W];
            end
        end
    end

    // Strobes follow master_ds live during ACTIVE so byte-lane changes
    // inside a cycle reach the slave without delay.
    always_comb begin
        slave_ds = '0;
        if (state_q == ACTIVE) begin
            for (int i = 0; i < NUM_SLAVES; i++) begin
                if (sel_q == SEL_W'(i)) begin
                    slave_ds[2*i +: 2] = master_ds;
                end
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        cnt_d     = cnt_q;
        rdata_d   = rdata_q;
        ack_d     = ack_q;
        berr_d    = berr_q;
        count_d   = count_q;
        enter_err = 1'b0;

        case (state_q)
            IDLE: begin
                if (ds_active) begin
                    if (hit) begin
                        sel_d   = hit_idx;
                        cnt_d   = '0;
                        state_d = ACTIVE;
                    end else begin
                        berr_d    = 1'b1;
                        enter_err = 1'b1;
                        state_d   = ERROR;
                    end
                end
            end
            ACTIVE: begin
                // A released strobe means the master abandoned the cycle;
                // that takes precedence over a coincident ack.
                if (!ds_active) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (sel_ack) begin
                    rdata_d = sel_rdata;
                    ack_d   = 1'b1;
                    state_d = DONE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    berr_d    = 1'b1;
                    enter_err = 1'b1;
                    state_d   = ERROR;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                if (!ds_active) begin
                    ack_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            ERROR: begin
                if (!ds_active) begin
                    berr_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (enter_err && (count_q != 8'hFF)) begin
            count_d = count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            sel_q   <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            ack_q   <= 1'b0;
            berr_q  <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
            berr_q  <= berr_d;
            count_q <= count_d;
        end
    end

    assign master_read = (state_q == DONE) ? rdata_q : '0;
    assign master_ack  = ack_q;
    assign master_berr = berr_q;
    assign berr_count  = count_q;

endmodule

// File: tb/tb_device_mux_n.sv
// tb/tb_device_mux_n.sv - self-checking bench for device_mux_n

module tb_device_mux_n;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] master_write;
    logic [15:0] master_read;
    logic [31:0] master_addr;
    logic [1:0]  master_ds;
    logic        master_ack;
    logic        master_berr;
    logic [7:0]  berr_count;
    logic [47:0] slave_read;
    logic [15:0] slave_write;
    logic [23:0] slave_addr;
    logic [5:0]  slave_ds;
    logic [2:0]  slave_ack;

    int checks = 0;
    int errors = 0;
    int berr_model = 0;

    device_mux_n #(.TIMEOUT(T)) dut (
        .clk(clk), .reset(reset),
        .master_write(master_write), .master_read(master_read),
        .master_addr(master_addr), .master_ds(master_ds),
        .master_ack(master_ack), .master_berr(master_berr),
        .berr_count(berr_count),
        .slave_read(slave_read), .slave_write(slave_write),
        .slave_addr(slave_addr), .slave_ds(slave_ds),
        .slave_ack(slave_ack)
    );

    always #5 clk = ~clk;

    localparam logic [31:0] W_BASE [3] = '{32'h0000_0000, 32'h0010_0000, 32'h0020_0000};
    localparam logic [31:0] W_MASK [3] = '{32'hFFF0_0000, 32'hFFFF_FF00, 32'hFFFF_0000};

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  ds;
        int          ack_at;   // ACTIVE cycle (1-based) in which the target acks
        logic [15:0] data;
        logic [15:0] wdata;
        int          exp_sel;  // -1 = unmapped
        bit          exp_ack;  // 1 = ack, 0 = bus error
        int          exp_lat;  // cycle (ds seen = 0) where ack/berr shows
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int decode(input logic [31:0] a);
        for (int i = 0; i < 3; i++)
            if ((a & W_MASK[i]) == W_BASE[i]) return i;
        return -1;
    endfunction

    // Transaction-level reference: outcome and latency from the decode and
    // timeout rules alone.
    task automatic model(input logic [31:0] a, input int ack_at,
                         output int sel, output bit ack, output int lat);
        sel = decode(a);
        if (sel < 0) begin
            ack = 1'b0; lat = 1;
        end else if (ack_at <= T) begin
            ack = 1'b1; lat = ack_at + 1;
        end else begin
            ack = 1'b0; lat = T + 1;
        end
    endtask

    // Enters right after a posedge with the DUT idle; leaves the same way.
    task automatic run_txn(input vec_t v, input string name);
        bit active;
        logic [5:0] exp_ds;
        bit done;
        master_addr  = v.addr;
        master_write = v.wdata;
        master_ds    = v.ds;
        slave_read   = {$urandom(), $urandom()};
        if (v.exp_sel >= 0) slave_read[v.exp_sel*16 +: 16] = v.data;
        slave_ack    = 3'b000;
        for (int c = 1; c <= v.exp_lat + 1; c++) begin
            @(posedge clk); #1;
            active = (v.exp_sel >= 0) && (c < v.exp_lat);
            slave_ack = 3'($urandom());
            if (active) slave_ack[v.exp_sel] = (c == v.ack_at);
            @(negedge clk);
            exp_ds = '0;
            if (active) exp_ds[2*v.exp_sel +: 2] = v.ds;
            done = (c >= v.exp_lat);
            chk({name, ".slave_ds"}, 32'(slave_ds), 32'(exp_ds));
            chk({name, ".ack"}, 32'(master_ack), 32'(v.exp_ack && done));
            chk({name, ".berr"}, 32'(master_berr), 32'(!v.exp_ack && done));
            chk({name, ".read"}, 32'(master_read), (v.exp_ack && done) ? 32'(v.data) : 32'h0);
            if (c == 1) begin
                chk({name, ".slave_addr"}, 32'(slave_addr), {8'h0, v.addr[23:0]});
                chk({name, ".slave_write"}, 32'(slave_write), 32'(v.wdata));
            end
        end
        if (!v.exp_ack && berr_model < 255) berr_model++;
        chk({name, ".berr_count"}, 32'(berr_count), 32'(berr_model));
        @(posedge clk); #1;
        master_ds = 2'b00;
        slave_ack = 3'b000;
        @(posedge clk);
        @(negedge clk);
        chk({name, ".rel_ack"}, 32'(master_ack), 32'h0);
        chk({name, ".rel_berr"}, 32'(master_berr), 32'h0);
        chk({name, ".rel_read"}, 32'(master_read), 32'h0);
        @(posedge clk); #1;
    endtask

    initial begin
        vec_t rv;
        int   sel;
        bit   ack;
        int   lat;

        vecs[0] = '{32'h0000_0010, 2'b11, 3,  16'hBEEF, 16'h0000, 0,  1'b1, 4};
        vecs[1] = '{32'h0010_0004, 2'b01, 1,  16'h1234, 16'h00A5, 1,  1'b1, 2};
        vecs[2] = '{32'h0030_0000, 2'b11, 1,  16'h0000, 16'h0000, -1, 1'b0, 1};
        vecs[3] = '{32'h0020_0000, 2'b11, 99, 16'h0000, 16'h0000, 2,  1'b0, T+1};
        vecs[4] = '{32'h0020_0010, 2'b10, 4,  16'hCAFE, 16'h0000, 2,  1'b1, 5};
        vecs[5] = '{32'h0010_0100, 2'b11, 1,  16'h0000, 16'h0000, -1, 1'b0, 1};
        vecs[6] = '{32'h000F_FFFF, 2'b11, 2,  16'h5A5A, 16'h0000, 0,  1'b1, 3};
        vecs[7] = '{32'h0020_FFFF, 2'b01, 2,  16'h7E81, 16'h0000, 2,  1'b1, 3};
        vecs[8] = '{32'h0021_0000, 2'b11, 1,  16'h0000, 16'h0000, -1, 1'b0, 1};
        vecs[9] = '{32'h8000_0010, 2'b11, 1,  16'h0000, 16'h0000, -1, 1'b0, 1};

        reset = 1'b1;
        master_addr = '0; master_write = '0; master_ds = 2'b00;
        slave_read = '0; slave_ack = '0;
        #1;
        chk("reset.ack", 32'(master_ack), 32'h0);
        chk("reset.berr", 32'(master_berr), 32'h0);
        chk("reset.read", 32'(master_read), 32'h0);
        chk("reset.count", 32'(berr_count), 32'h0);
        chk("reset.slave_ds", 32'(slave_ds), 32'h0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0: rv.addr = {12'h000, 20'($urandom())};
                1: rv.addr = {24'h001000, 8'($urandom())};
                2: rv.addr = {16'h0020, 16'($urandom())};
                default: rv.addr = $urandom();
            endcase
            rv.ds     = 2'($urandom_range(1, 3));
            rv.ack_at = $urandom_range(1, T + 2);
            rv.data   = 16'($urandom());
            rv.wdata  = 16'($urandom());
            model(rv.addr, rv.ack_at, sel, ack, lat);
            rv.exp_sel = sel; rv.exp_ack = ack; rv.exp_lat = lat;
            run_txn(rv, $sformatf("rnd%0d", i));
        end

        // Master abort after two ACTIVE cycles.
        master_addr = 32'h0020_0000; master_ds = 2'b11; slave_ack = 3'b000;
        repeat (2) begin
            @(posedge clk); @(negedge clk);
            chk("abort.slave_ds", 32'(slave_ds), 32'h30);
        end
        @(posedge clk); #1 master_ds = 2'b00;
        repeat (T + 2) begin
            @(negedge clk);
            chk("abort.ack", 32'(master_ack), 32'h0);
            chk("abort.berr", 32'(master_berr), 32'h0);
            chk("abort.slave_ds", 32'(slave_ds), 32'h0);
            @(posedge clk); #1;
        end
        chk("abort.count", 32'(berr_count), 32'(berr_model));

        // Byte strobes changing mid-cycle pass straight through.
        master_addr = 32'h0010_0008; master_ds = 2'b01;
        @(posedge clk); @(negedge clk);
        chk("midds.first", 32'(slave_ds), 32'h04);
        @(posedge clk); #1 master_ds = 2'b10; slave_read[31:16] = 16'h3C3C; slave_ack = 3'b010;
        @(negedge clk);
        chk("midds.second", 32'(slave_ds), 32'h08);
        @(posedge clk); #1 slave_ack = 3'b000;
        @(negedge clk);
        chk("midds.ack", 32'(master_ack), 32'h1);
        chk("midds.read", 32'(master_read), 32'h3C3C);
        @(posedge clk); #1 master_ds = 2'b00;
        @(posedge clk); @(posedge clk); #1;

        // Reset asserted while in DONE clears outputs without a clock edge.
        master_addr = 32'h0000_0020; master_ds = 2'b11; slave_read[15:0] = 16'h9876;
        @(posedge clk); #1 slave_ack = 3'b001;
        @(posedge clk); #1 slave_ack = 3'b000;
        @(negedge clk);
        chk("rstdone.ack_before", 32'(master_ack), 32'h1);
        chk("rstdone.read_before", 32'(master_read), 32'h9876);
        chk("rstdone.count_before", 32'(berr_count), 32'(berr_model));
        #2 reset = 1'b1;
        #1;
        chk("rstdone.ack", 32'(master_ack), 32'h0);
        chk("rstdone.read", 32'(master_read), 32'h0);
        chk("rstdone.count", 32'(berr_count), 32'h0);
        berr_model = 0;
        master_ds = 2'b00;
        @(posedge clk); #1 reset = 1'b0;
        @(posedge clk); #1;

        // Saturation: 260 unmapped cycles.
        master_addr = 32'h0030_0000;
        for (int i = 1; i <= 260; i++) begin
            master_ds = 2'b11;
            @(posedge clk); #1 master_ds = 2'b00;
            @(posedge clk); #1;
            if (berr_model < 255) berr_model++;
            if (i == 100 || i == 254 || i == 255 || i == 260)
                chk($sformatf("sat.count%0d", i), 32'(berr_count), 32'(berr_model));
        end
        chk("sat.final", 32'(berr_count), 32'd255);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
